fila_ctrl: RTL and testbench



---
 rtl/fila_pkg.sv | 11 +
 rtl/fila_rr_arb.sv | 15 +
 rtl/fila_ctrl.sv | 159 +++++++++++++++
 tb/tb_fila_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// Shared types and constants for the fila queue controller.
package fila_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} ctrl_state_t;

    localparam logic OP_ENQ       = 1'b0;
    localparam logic OP_DEQ       = 1'b1;
    localparam int   FILA_DEPTH   = 8;
    localparam int   DEFAULT_WAIT = 3;

endpackage

// File: rtl/fila_rr_arb.sv
// Two-way round-robin arbiter: ptr breaks the tie when both requesters are pending.
module fila_rr_arb (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant_idx,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) grant_idx = ptr;
        else              grant_idx = req[1];
    end

endmodule

// File: rtl/fila_ctrl.sv
// Round-robin controller sharing one fila byte queue between two requesters.
// Define FILA_CTRL_STATS_EN to add saturating 16-bit enqueue/dequeue/reject counters.
module fila_ctrl
    import fila_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = FILA_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT
) (
    input  logic                clock_10KHz,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_op,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          ack,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                busy,
    output logic                fila_enqueue,
    output logic                fila_dequeue,
    output logic [DATA_W-1:0]   fila_data,
    input  logic [7:0]          fila_len,
    input  logic [DATA_W-1:0]   fila_dout
`ifdef FILA_CTRL_STATS_EN
    ,
    output logic [15:0]         stat_enq,
    output logic [15:0]         stat_deq,
    output logic [15:0]         stat_rej
`endif
);

    localparam logic [7:0] DEPTH_8 = 8'(DEPTH);
    localparam logic [3:0] WAIT_4  = 4'(WAIT_CYCLES);

    ctrl_state_t         r_state, w_state_nxt;
    logic                r_rr;
    logic                r_g;
    logic                r_op;
    logic [DATA_W-1:0]   r_data;
    logic [3:0]          r_cnt;
    logic [1:0]          r_ack;
    logic                r_err;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_enq;
    logic                r_deq;

    logic                w_gidx;
    logic                w_gvld;
    logic                w_sel_op;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_reject;

    fila_rr_arb u_arb (
        .req         (req_valid),
        .ptr         (r_rr),
        .grant_idx   (w_gidx),
        .grant_valid (w_gvld)
    );

    assign w_sel_op   = req_op[w_gidx];
    assign w_sel_data = w_gidx ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    assign w_reject   = (w_sel_op == OP_ENQ) ? (fila_len >= DEPTH_8) : (fila_len == 8'd0);

    always_ff @(posedge clock_10KHz) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_gvld) w_state_nxt = w_reject ? DONE : ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (r_cnt == 4'd1) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ack/err are registered on the edge entering DONE so they are high exactly during DONE.
    always_ff @(posedge clock_10KHz) begin
        if (reset) begin
            r_rr       <= 1'b0;
            r_g        <= 1'b0;
            r_op       <= OP_ENQ;
            r_data     <= '0;
            r_cnt      <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_rsp_data <= '0;
            r_enq      <= 1'b0;
            r_deq      <= 1'b0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            r_enq <= 1'b0;
            r_deq <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gvld) begin
                        r_g    <= w_gidx;
                        r_op   <= w_sel_op;
                        r_data <= w_sel_data;
                        if (w_reject) begin
                            r_ack <= {w_gidx, ~w_gidx};
                            r_err <= 1'b1;
                        end else begin
                            r_enq <= (w_sel_op == OP_ENQ);
                            r_deq <= (w_sel_op == OP_DEQ);
                        end
                    end
                end
                ISSUE: r_cnt <= WAIT_4;
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_ack <= {r_g, ~r_g};
                        if (r_op == OP_DEQ) r_rsp_data <= fila_dout;
                    end
                end
                DONE:    r_rr <= ~r_g;
                default: ;
            endcase
        end
    end

    assign ack          = r_ack;
    assign rsp_err      = r_err;
    assign rsp_data     = r_rsp_data;
    assign busy         = (r_state != IDLE);
    assign fila_enqueue = r_enq;
    assign fila_dequeue = r_deq;
    assign fila_data    = (r_state == ISSUE || r_state == WAIT) ? r_data : '0;

`ifdef FILA_CTRL_STATS_EN
    logic [15:0] r_stat_enq, r_stat_deq, r_stat_rej;

    always_ff @(posedge clock_10KHz) begin
        if (reset) begin
            r_stat_enq <= '0;
            r_stat_deq <= '0;
            r_stat_rej <= '0;
        end else if (r_state == DONE) begin
            if (r_err) begin
                if (r_stat_rej != 16'hFFFF) r_stat_rej <= r_stat_rej + 16'd1;
            end else if (r_op == OP_ENQ) begin
                if (r_stat_enq != 16'hFFFF) r_stat_enq <= r_stat_enq + 16'd1;
            end else begin
                if (r_stat_deq != 16'hFFFF) r_stat_deq <= r_stat_deq + 16'd1;
            end
        end
    end

    assign stat_enq = r_stat_enq;
    assign stat_deq = r_stat_deq;
    assign stat_rej = r_stat_rej;
`endif

endmodule

// File: tb/tb_fila_ctrl.sv
// Self-checking bench for fila_ctrl with a behavioural fila stand-in and queue reference model.
module tb_fila_ctrl;
    import fila_pkg::*;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_op;
    logic [2*DW-1:0] req_data;
    logic [1:0]      ack;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;
    logic            busy;
    logic            fila_enqueue;
    logic            fila_dequeue;
    logic [DW-1:0]   fila_data;
    logic [7:0]      fila_len;
    logic [DW-1:0]   fila_dout;
`ifdef FILA_CTRL_STATS_EN
    logic [15:0]     stat_enq, stat_deq, stat_rej;
`endif

    always #5 clk = ~clk;

    fila_ctrl #(.DATA_W(DW), .DEPTH(8), .WAIT_CYCLES(3)) dut (
        .clock_10KHz  (clk),
        .reset        (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_data     (req_data),
        .ack          (ack),
        .rsp_err      (rsp_err),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .fila_enqueue (fila_enqueue),
        .fila_dequeue (fila_dequeue),
        .fila_data    (fila_data),
        .fila_len     (fila_len),
        .fila_dout    (fila_dout)
`ifdef FILA_CTRL_STATS_EN
        ,
        .stat_enq     (stat_enq),
        .stat_deq     (stat_deq),
        .stat_rej     (stat_rej)
`endif
    );

    // Stand-in for the fila instance: 8-deep byte queue reacting to command pulses.
    byte unsigned fq[$];
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fila_len  <= 8'd0;
            fila_dout <= '0;
        end else begin
            if (fila_enqueue && fq.size() < 8) fq.push_back(fila_data);
            if (fila_dequeue && fq.size() > 0) fila_dout <= fq.pop_front();
            fila_len <= 8'(fq.size());
        end
    end

    int n_enq_p, n_deq_p, n_ack_cyc;
    bit both_ack;
    always @(posedge clk) begin
        if (fila_enqueue === 1'b1) n_enq_p++;
        if (fila_dequeue === 1'b1) n_deq_p++;
    end
    always @(negedge clk) begin
        if (ack === 2'b11) both_ack = 1'b1;
        if (ack !== 2'b00) n_ack_cyc++;
    end

    // Reference model: expected queue contents, last-grant pointer and stat counts.
    byte unsigned mq[$];
    bit m_rr;
    int m_enq, m_deq, m_rej;

    int n_chk, n_pass, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_rr = 1'b0;
        m_enq = 0; m_deq = 0; m_rej = 0;
    endtask

    // Called on a negedge while the DUT is idle; returns the predicted grant.
    task automatic txn(input logic [1:0] mask, input logic [1:0] ops,
                       input logic [15:0] data, input bit drop, output bit g);
        bit op, err;
        byte unsigned d, exp_d;
        int lat;
        g  = (mask == 2'b11) ? m_rr : mask[1];
        op = ops[g];
        d  = g ? data[15:8] : data[7:0];
        exp_d = 8'h00;
        err = (op == OP_ENQ) ? (mq.size() >= 8) : (mq.size() == 0);
        if (err) m_rej++;
        else if (op == OP_ENQ) begin mq.push_back(d); m_enq++; end
        else begin exp_d = mq.pop_front(); m_deq++; end
        m_rr = ~g;

        req_valid = mask;
        req_op    = ops;
        req_data  = data;
        n_enq_p = 0;
        n_deq_p = 0;
        lat = 0;
        while (ack === 2'b00 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (drop) req_valid = 2'b00;
        chk("latency", 32'(lat), err ? 32'd1 : 32'd5);
        chk("ack", 32'(ack), g ? 32'd2 : 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(err));
        if (op == OP_DEQ && !err) chk("rsp_data", 32'(rsp_data), 32'(exp_d));
        @(negedge clk);
        chk("enq_pulses", 32'(n_enq_p), (!err && op == OP_ENQ) ? 32'd1 : 32'd0);
        chk("deq_pulses", 32'(n_deq_p), (!err && op == OP_DEQ) ? 32'd1 : 32'd0);
        chk("fila_len", 32'(fila_len), 32'(mq.size()));
    endtask

    initial begin
        bit g;
        n_chk = 0; n_pass = 0; n_fail = 0;
        both_ack = 1'b0;
        req_valid = '0; req_op = '0; req_data = '0;
        do_reset();

        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd", 32'({fila_enqueue, fila_dequeue}), 32'd0);
        chk("rst_fdata", 32'(fila_data), 32'd0);

        // Directed: enqueue A5, then the dequeue ordering and empty/full boundaries.
        txn(2'b01, 2'b00, 16'h00A5, 1'b1, g);
        txn(2'b10, 2'b10, 16'h0000, 1'b1, g);
        txn(2'b01, 2'b00, 16'h0011, 1'b1, g);
        txn(2'b01, 2'b00, 16'h0022, 1'b1, g);
        txn(2'b10, 2'b10, 16'h0000, 1'b1, g);
        txn(2'b10, 2'b10, 16'h0000, 1'b1, g);
        txn(2'b10, 2'b10, 16'h0000, 1'b1, g);
        for (int i = 0; i < 9; i++) txn(2'b01, 2'b00, 16'(8'h30 + i), 1'b1, g);
        for (int i = 0; i < 8; i++) txn(2'b11, 2'b11, 16'h0000, 1'b1, g);

        // Both requesters permanently valid: grants must alternate from 0.
        do_reset();
        both_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            txn(2'b11, 2'(i % 3 == 2 ? 3 : 0), 16'($urandom), (i == 5), g);
            chk("grant_order", 32'(g), 32'(i % 2));
        end

        // Randomised traffic against the reference model.
        for (int i = 0; i < 60; i++)
            txn(2'($urandom_range(1, 3)), 2'($urandom), 16'($urandom), 1'b1, g);
`ifdef FILA_CTRL_STATS_EN
        chk("stat_enq", 32'(stat_enq), 32'(m_enq));
        chk("stat_deq", 32'(stat_deq), 32'(m_deq));
        chk("stat_rej", 32'(stat_rej), 32'(m_rej));
`endif
        chk("never_both_ack", 32'(both_ack), 32'd0);

        // Reset during WAIT aborts the transaction with no ack.
        txn(2'b01, 2'b00, 16'h0077, 1'b1, g);
        req_valid = 2'b01; req_op = 2'b00; req_data = 16'h0099;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_err", 32'(rsp_err), 32'd0);
        chk("abort_rdata", 32'(rsp_data), 32'd0);
        chk("abort_cmd", 32'({fila_enqueue, fila_dequeue}), 32'd0);
        chk("abort_fdata", 32'(fila_data), 32'd0);
`ifdef FILA_CTRL_STATS_EN
        chk("abort_stats", 32'({stat_enq | stat_deq | stat_rej}), 32'd0);
`endif
        req_valid = 2'b00;
        rst = 1'b0;
        mq.delete();
        m_rr = 1'b0;
        n_ack_cyc = 0;
        repeat (8) @(negedge clk);
        chk("abort_no_ack", 32'(n_ack_cyc), 32'd0);
        txn(2'b11, 2'b00, 16'h5A3C, 1'b1, g);
        chk("post_abort_grant", 32'(g), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
